pipe_advance_ctrl: RTL

PIPE_ADVANCE_CTRL -- requirements
Module: pipe_advance_ctrl

---
 rtl/pipe_advance_ctrl_pkg.sv | 21 ++
 rtl/pipe_advance_ctrl_stage_reg.sv | 35 +++
 rtl/pipe_advance_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_advance_ctrl_pkg.sv
// Shared CPU pipeline definitions: the stage record, the bubble constant and the opcode field.
package pipe_advance_ctrl_pkg;

    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;
    localparam int          OPC_MSB      = 15;
    localparam int          OPC_LSB      = 13;

    typedef struct packed {
        logic [15:0] instr;
        logic        write;
        logic        regdst;
        logic        valid;
    } stage_t;

    localparam stage_t BUBBLE_STAGE = '{instr: BUBBLE_INSTR, write: 1'b0, regdst: 1'b0, valid: 1'b0};

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pipe_advance_ctrl_stage_reg.sv
// One pipeline stage register: reset and bubble clear it, load captures d, otherwise it holds.
module pipe_stage_reg
    import pipe_advance_ctrl_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (bubble) begin
            stage_d = BUBBLE_STAGE;
        end else if (load) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage_q <= BUBBLE_STAGE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/pipe_advance_ctrl.sv
// IF/ID/EX pipeline advance control: stall holds IFID, flush clears IFID and IDEX,
// EXMEM always advances; counts injected bubbles and watches for stuck stalls.
module pipe_advance_ctrl
    import pipe_advance_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush,
    input  logic [15:0] fetch_instr,
    input  logic        fetch_valid,
    input  logic        id_write,
    input  logic        id_regdst,
    output logic [15:0] IFID,
    output logic [15:0] IDEX,
    output logic [15:0] EXMEM,
    output logic        IDEXWrite,
    output logic        IDEXRegDst,
    output logic        EXMEMWrite,
    output logic        EXMEMRegDst,
    output logic        ifid_valid,
    output logic        idex_valid,
    output logic        exmem_valid,
    output logic [7:0]  bubble_count,
    output logic        stall_timeout
);

    localparam logic [3:0] STALL_LIMIT = 4'(STALL_MAX);

    stage_t ifid_q, idex_q, exmem_q;
    stage_t ifid_in, idex_in;
    logic   hold_front;
    logic   inject;

    logic [7:0] bubble_cnt_q, bubble_cnt_d;
    logic [3:0] stall_run_q, stall_run_d;
    logic       timeout_q, timeout_d;

    assign hold_front = stall_in && !flush;
    assign inject     = stall_in || flush;

    always_comb begin
        ifid_in = BUBBLE_STAGE;
        if (fetch_valid) begin
            ifid_in = '{instr: fetch_instr, write: 1'b0, regdst: 1'b0, valid: 1'b1};
        end
        idex_in = '{instr: ifid_q.instr, write: id_write, regdst: id_regdst, valid: ifid_q.valid};
    end

    pipe_stage_reg u_ifid (
        .clock (clock),
        .reset (reset),
        .load  (!hold_front),
        .bubble(flush),
        .d     (ifid_in),
        .q     (ifid_q)
    );

    pipe_stage_reg u_idex (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .bubble(inject),
        .d     (idex_in),
        .q     (idex_q)
    );

    pipe_stage_reg u_exmem (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .bubble(1'b0),
        .d     (idex_q),
        .q     (exmem_q)
    );

    // Run length saturates at 15 so a long stall cannot wrap back under the limit.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (inject && bubble_cnt_q != 8'hFF) begin
            bubble_cnt_d = bubble_cnt_q + 8'd1;
        end
        stall_run_d = 4'd0;
        if (hold_front) begin
            stall_run_d = (stall_run_q == 4'hF) ? 4'hF : stall_run_q + 4'd1;
        end
        timeout_d = timeout_q || (stall_run_d >= STALL_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bubble_cnt_q <= 8'd0;
            stall_run_q  <= 4'd0;
            timeout_q    <= 1'b0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_run_q  <= stall_run_d;
            timeout_q    <= timeout_d;
        end
    end

    logic unused_ifid_ctrl;
    assign unused_ifid_ctrl = ifid_q.write ^ ifid_q.regdst;

    assign IFID          = ifid_q.instr;
    assign ifid_valid    = ifid_q.valid;
    assign IDEX          = idex_q.instr;
    assign IDEXWrite     = idex_q.write;
    assign IDEXRegDst    = idex_q.regdst;
    assign idex_valid    = idex_q.valid;
    assign EXMEM         = exmem_q.instr;
    assign EXMEMWrite    = exmem_q.write;
    assign EXMEMRegDst   = exmem_q.regdst;
    assign exmem_valid   = exmem_q.valid;
    assign bubble_count  = bubble_cnt_q;
    assign stall_timeout = timeout_q;

endmodule
